// File: rtl/cla_pipelined_adder_if.sv
// Handshake bundle for cla_pipelined_adder.
// CLA_OVERFLOW_EN adds the ovf output.
interface cla_pipelined_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             P_word_block;
  logic             G_word_block;
`ifdef CLA_OVERFLOW_EN
  logic             ovf;
`endif

  modport master (
    output in_valid, in1, in2, cin,
    output out_ready,
    input  in_ready, out_valid, sum,
    input  cout, P_word_block, G_word_block
`ifdef CLA_OVERFLOW_EN
    , input ovf
`endif
  );

  modport slave (
    input  in_valid, in1, in2, cin,
    input  out_ready,
    output in_ready, out_valid, sum,
    output cout, P_word_block, G_word_block
`ifdef CLA_OVERFLOW_EN
    , output ovf
`endif
  );
endinterface

// File: rtl/cla_pipelined_adder.sv
// Two-stage two-level carry look-ahead adder with valid/ready.
// CLA_OVERFLOW_EN adds a registered signed-overflow output.
module cla_pipelined_adder #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  cla_pipelined_adder_if.slave io
);
  localparam int NGRP = WIDTH / 4;

  logic             s1_valid_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             cin_q;
  logic [NGRP-1:0]  pg_q, gg_q;
  logic [NGRP-1:0]  pg_d, gg_d;
  logic [WIDTH-1:0] pb, gb;

  logic             out_valid_q;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             pw_q, pw_d;
  logic             gw_q, gw_d;

  logic [WIDTH-1:0] p2, g2, bc;
  logic [NGRP:0]    gc;
  logic             prod_g, acc_g;
  logic             prod_b, acc_b;

  logic             s1_load, s2_load;

  assign s2_load = !out_valid_q || io.out_ready;
  assign s1_load = !s1_valid_q || s2_load;

  always_comb begin
    pb   = io.in1 ^ io.in2;
    gb   = io.in1 & io.in2;
    pg_d = '0;
    gg_d = '0;
    for (int i = 0; i < NGRP; i++) begin
      pg_d[i] = &pb[4*i +: 4];
      gg_d[i] = gb[4*i+3]
              | (pb[4*i+3] & gb[4*i+2])
              | (pb[4*i+3] & pb[4*i+2] & gb[4*i+1])
              | (pb[4*i+3] & pb[4*i+2] & pb[4*i+1]
                 & gb[4*i]);
    end
  end

  // Each group carry is a flat sum of products, no ripple.
  always_comb begin
    gc     = '0;
    gc[0]  = cin_q;
    prod_g = 1'b1;
    acc_g  = 1'b0;
    for (int i = 0; i < NGRP; i++) begin
      prod_g = 1'b1;
      acc_g  = 1'b0;
      for (int j = i; j >= 0; j--) begin
        acc_g  = acc_g | (prod_g & gg_q[j]);
        prod_g = prod_g & pg_q[j];
      end
      gc[i+1] = acc_g | (prod_g & cin_q);
    end
    gw_d = acc_g;
    pw_d = &pg_q;
  end

  always_comb begin
    p2     = a_q ^ b_q;
    g2     = a_q & b_q;
    bc     = '0;
    prod_b = 1'b1;
    acc_b  = 1'b0;
    for (int i = 0; i < NGRP; i++) begin
      for (int k = 0; k < 4; k++) begin
        prod_b = 1'b1;
        acc_b  = 1'b0;
        for (int j = k - 1; j >= 0; j--) begin
          acc_b  = acc_b | (prod_b & g2[4*i+j]);
          prod_b = prod_b & p2[4*i+j];
        end
        bc[4*i+k] = acc_b | (prod_b & gc[i]);
      end
    end
    sum_d  = p2 ^ bc;
    cout_d = gc[NGRP];
  end

`ifdef CLA_OVERFLOW_EN
  logic ovf_q, ovf_d;
  assign ovf_d  = bc[WIDTH-1] ^ gc[NGRP];
  assign io.ovf = ovf_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      cin_q       <= 1'b0;
      pg_q        <= '0;
      gg_q        <= '0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      pw_q        <= 1'b0;
      gw_q        <= 1'b0;
`ifdef CLA_OVERFLOW_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      if (s1_load) begin
        s1_valid_q <= io.in_valid;
        a_q        <= io.in1;
        b_q        <= io.in2;
        cin_q      <= io.cin;
        pg_q       <= pg_d;
        gg_q       <= gg_d;
      end
      if (s2_load) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          sum_q  <= sum_d;
          cout_q <= cout_d;
          pw_q   <= pw_d;
          gw_q   <= gw_d;
`ifdef CLA_OVERFLOW_EN
          ovf_q  <= ovf_d;
`endif
        end
      end
    end
  end

  assign io.in_ready     = s1_load;
  assign io.out_valid    = out_valid_q;
  assign io.sum          = sum_q;
  assign io.cout         = cout_q;
  assign io.P_word_block = pw_q;
  assign io.G_word_block = gw_q;
endmodule
